// File: rtl/sid_lookup_seq.sv
// sid_lookup_seq: shares one waveform lookup table between VOICES voices.
// A ce_1m strobe starts a sequence. Each voice gets a SLOT-cycle window.
// The voice's table address is issued at offset 1 of its window, and the
// four table bytes are captured LAT+1 cycles later, at offset 2+LAT.
module sid_lookup_seq #(
    parameter int VOICES = 3,
    parameter int SLOT   = 8,
    parameter int LAT    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce_1m,
    input  logic [12*VOICES-1:0] acc_ps_in,
    input  logic [12*VOICES-1:0] acc_t_in,
    output logic [11:0]          tbl_acc_ps,
    output logic [11:0]          tbl_acc_t,
    input  logic [7:0]           tbl_st,
    input  logic [7:0]           tbl_pt,
    input  logic [7:0]           tbl_ps,
    input  logic [7:0]           tbl_pst,
    output logic [8*VOICES-1:0]  st_out,
    output logic [8*VOICES-1:0]  pt_out,
    output logic [8*VOICES-1:0]  ps_out,
    output logic [8*VOICES-1:0]  pst_out,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    input  logic                 ovr_clr
);

    localparam int TERM    = VOICES * SLOT;
    localparam int CW      = $clog2(TERM + 1);
    localparam int LASTCAP = (VOICES - 1) * SLOT + 2 + LAT;

    localparam logic [CW-1:0] TERM_C = CW'(TERM);
    localparam logic [CW-1:0] LAST_C = CW'(LASTCAP);

    if (SLOT < LAT + 2) begin : g_chk_slot
        $error("sid_lookup_seq: SLOT must be at least LAT+2");
    end
    if (VOICES < 1 || VOICES > 8) begin : g_chk_voices
        $error("sid_lookup_seq: VOICES must be 1..8");
    end
    if (LAT < 1 || LAT > 6) begin : g_chk_lat
        $error("sid_lookup_seq: LAT must be 1..6");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic [11:0]   acc_ps_q, acc_ps_d;
    logic [11:0]   acc_t_q, acc_t_d;
    logic          last_cap;

    // busy_q marks the capture window. It is kept apart from cnt because when
    // SLOT == LAT+2 the last capture count equals the idle count TERM.
    assign last_cap = busy_q && (cnt_q == LAST_C);

    // Slot counter: a restart wins over the increment, and the count saturates at TERM
    always_comb begin
        cnt_d = cnt_q;
        if (ce_1m)
            cnt_d = '0;
        else if (cnt_q != TERM_C)
            cnt_d = cnt_q + CW'(1);
    end

    // Sequence status: busy, done pulse, and sticky overrun (a set beats a clear)
    always_comb begin
        busy_d = busy_q;
        if (ce_1m)
            busy_d = 1'b1;
        else if (last_cap)
            busy_d = 1'b0;

        done_d = last_cap;

        ovr_d = ovr_q;
        if (ce_1m && busy_q)
            ovr_d = 1'b1;
        else if (ovr_clr)
            ovr_d = 1'b0;
    end

    // Address issue: load voice v's indices at offset 1 of its slot, and hold them otherwise
    always_comb begin
        acc_ps_d = acc_ps_q;
        acc_t_d  = acc_t_q;
        for (int v = 0; v < VOICES; v++) begin
            if (busy_q && cnt_q == CW'(v * SLOT + 1)) begin
                acc_ps_d = acc_ps_in[12*v +: 12];
                acc_t_d  = acc_t_in[12*v +: 12];
            end
        end
    end

    // Sequencer state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= TERM_C;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            acc_ps_q <= '0;
            acc_t_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            acc_ps_q <= acc_ps_d;
            acc_t_q  <= acc_t_d;
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        localparam logic [CW-1:0] CAP = CW'(v * SLOT + 2 + LAT);
        logic [7:0] st_q, pt_q, ps_q, pst_q;

        // Capture this voice's four table bytes at its capture slot, and hold them otherwise
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                st_q  <= '0;
                pt_q  <= '0;
                ps_q  <= '0;
                pst_q <= '0;
            end else if (busy_q && cnt_q == CAP) begin
                st_q  <= tbl_st;
                pt_q  <= tbl_pt;
                ps_q  <= tbl_ps;
                pst_q <= tbl_pst;
            end
        end

        assign st_out[8*v +: 8]  = st_q;
        assign pt_out[8*v +: 8]  = pt_q;
        assign ps_out[8*v +: 8]  = ps_q;
        assign pst_out[8*v +: 8] = pst_q;
    end

    assign tbl_acc_ps = acc_ps_q;
    assign tbl_acc_t  = acc_t_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sid_lookup_seq.sv
// Bench for sid_lookup_seq. It runs directed and random ce_1m sequences
// against a table model with LAT-cycle latency. A per-sequence arithmetic
// model pushes the expected results into a queue, and a monitor checks them
// on each done pulse.
module tb_sid_lookup_seq;
    localparam int V       = 3;
    localparam int SLOT    = 8;
    localparam int LAT     = 2;
    localparam int LASTCAP = (V - 1) * SLOT + 2 + LAT;

    logic clk = 1'b0, reset_n = 1'b0, ce_1m = 1'b0, ovr_clr = 1'b0;
    logic [12*V-1:0] acc_ps_in = '0, acc_t_in = '0;
    logic [11:0] tbl_acc_ps, tbl_acc_t;
    logic [7:0]  tbl_st, tbl_pt, tbl_ps, tbl_pst;
    logic [8*V-1:0] st_out, pt_out, ps_out, pst_out;
    logic busy, done, overrun;

    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    sid_lookup_seq #(.VOICES(V), .SLOT(SLOT), .LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m),
        .acc_ps_in(acc_ps_in), .acc_t_in(acc_t_in),
        .tbl_acc_ps(tbl_acc_ps), .tbl_acc_t(tbl_acc_t),
        .tbl_st(tbl_st), .tbl_pt(tbl_pt), .tbl_ps(tbl_ps), .tbl_pst(tbl_pst),
        .st_out(st_out), .pt_out(pt_out), .ps_out(ps_out), .pst_out(pst_out),
        .busy(busy), .done(done), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    // Table model: data reflects the address presented LAT cycles earlier
    logic [23:0] tpipe [LAT] = '{default: '0};
    logic [11:0] ta, tb;
    always @(posedge clk) begin
        tpipe[0] <= {tbl_acc_ps, tbl_acc_t};
        for (int k = 1; k < LAT; k++) tpipe[k] <= tpipe[k-1];
    end
    assign ta      = tpipe[LAT-1][23:12];
    assign tb      = tpipe[LAT-1][11:0];
    assign tbl_st  = ta[7:0];
    assign tbl_pt  = ta[11:4];
    assign tbl_ps  = tb[7:0];
    assign tbl_pst = ta[7:0] ^ tb[7:0];

    typedef struct {
        logic [8*V-1:0] st, pt, ps, pst;
        logic           ovr;
    } rec_t;
    rec_t q[$];
    rec_t mr;

    // Model state
    logic [8*V-1:0] e_st = '0, e_pt = '0, e_ps = '0, e_pst = '0;
    logic  e_ovr = 1'b0;
    bit    prev_ovr_run = 1'b0;
    bit    prev_fin_eq = 1'b0;
    logic [11:0] in_ps [V];
    logic [11:0] in_t  [V];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: each done pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (reset_n && done === 1'b1) begin
            if (q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
            end else begin
                mr = q.pop_front();
                chk("done_st", st_out, mr.st);
                chk("done_pt", pt_out, mr.pt);
                chk("done_ps", ps_out, mr.ps);
                chk("done_pst", pst_out, mr.pst);
                chk("done_ovr", overrun, mr.ovr);
            end
        end
    end

    // One ce_1m followed by n-1 quiet cycles, so the next ce lands at cnt == n-1
    task automatic run_seq(input int n, input bit clr, input bit fixed);
        rec_t r;
        for (int v = 0; v < V; v++) begin
            in_ps[v] = 12'($urandom_range(0, 4095));
            in_t[v]  = 12'($urandom_range(0, 4095));
        end
        if (fixed) begin
            in_ps[0] = 12'h123;
            in_t[0]  = 12'h045;
        end
        for (int v = 0; v < V; v++) begin
            acc_ps_in[12*v +: 12] = in_ps[v];
            acc_t_in[12*v +: 12]  = in_t[v];
        end
        ce_1m = 1'b1; ovr_clr = clr;
        tick;
        ce_1m = 1'b0; ovr_clr = 1'b0;
        // cnt == 0: the previous sequence is fully settled
        if (prev_ovr_run) e_ovr = 1'b1;
        else if (clr) e_ovr = 1'b0;
        chk("held_st", st_out, e_st);
        chk("held_pt", pt_out, e_pt);
        chk("held_ps", ps_out, e_ps);
        chk("held_pst", pst_out, e_pst);
        chk("overrun", overrun, e_ovr);
        chk("busy_c0", busy, 1'b1);
        chk("done_c0", done, prev_fin_eq);
        for (int v = 0; v < V; v++) begin
            if (v * SLOT + 2 + LAT <= n - 1) begin
                e_st[8*v +: 8]  = in_ps[v][7:0];
                e_pt[8*v +: 8]  = in_ps[v][11:4];
                e_ps[8*v +: 8]  = in_t[v][7:0];
                e_pst[8*v +: 8] = in_ps[v][7:0] ^ in_t[v][7:0];
            end
        end
        if (n - 1 >= LASTCAP) begin
            r.st = e_st; r.pt = e_pt; r.ps = e_ps; r.pst = e_pst;
            r.ovr = (n - 1 == LASTCAP) ? 1'b1 : e_ovr;
            q.push_back(r);
        end
        for (int j = 1; j < n; j++) begin
            tick;
            chk("busy", busy, (j <= LASTCAP));
            chk("done", done, (j == LASTCAP + 1));
            for (int v = 0; v < V; v++) begin
                if (j == v * SLOT + 2) begin
                    chk("addr_ps", tbl_acc_ps, in_ps[v]);
                    chk("addr_t", tbl_acc_t, in_t[v]);
                end
            end
        end
        prev_ovr_run = (n - 1 <= LASTCAP);
        prev_fin_eq  = (n - 1 == LASTCAP);
    endtask

    task automatic chk_reset_state;
        chk("rst_st", st_out, 0);
        chk("rst_pt", pt_out, 0);
        chk("rst_ps", ps_out, 0);
        chk("rst_pst", pst_out, 0);
        chk("rst_addr_ps", tbl_acc_ps, 0);
        chk("rst_addr_t", tbl_acc_t, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset while ce_1m and ovr_clr are held high; both must be ignored
        reset_n = 1'b0; ce_1m = 1'b1; ovr_clr = 1'b1;
        repeat (3) tick;
        chk_reset_state();
        ce_1m = 1'b0; ovr_clr = 1'b0;
        tick;
        reset_n = 1'b1;
        repeat (2) tick;
        chk("idle_busy", busy, 1'b0);

        // Full sequence with fixed voice 0 indices
        run_seq(30, 1'b0, 1'b1);
        chk("v0_st", st_out[7:0], 8'h23);
        chk("v0_pt", pt_out[7:0], 8'h12);
        chk("v0_ps", ps_out[7:0], 8'h45);
        chk("v0_pst", pst_out[7:0], 8'h66);

        // Restart at cnt 10, then a clean sequence
        run_seq(11, 1'b0, 1'b0);
        run_seq(30, 1'b0, 1'b0);
        // An overrunning ce_1m together with ovr_clr: the set wins
        run_seq(11, 1'b0, 1'b0);
        run_seq(30, 1'b1, 1'b0);
        ovr_clr = 1'b1;
        tick;
        ovr_clr = 1'b0;
        e_ovr = 1'b0;
        chk("ovr_clr", overrun, 1'b0);

        // ce_1m in the final-capture cycle
        run_seq(LASTCAP + 1, 1'b0, 1'b0);
        run_seq(30, 1'b0, 1'b0);

        // Reset at cnt 6 of an overrunning sequence
        run_seq(5, 1'b0, 1'b0);
        for (int v = 0; v < V; v++) begin
            acc_ps_in[12*v +: 12] = 12'($urandom_range(0, 4095));
            acc_t_in[12*v +: 12]  = 12'($urandom_range(0, 4095));
        end
        ce_1m = 1'b1;
        tick;
        ce_1m = 1'b0;
        repeat (6) tick;
        reset_n = 1'b0; ce_1m = 1'b1; ovr_clr = 1'b1;
        tick;
        chk_reset_state();
        ce_1m = 1'b0; ovr_clr = 1'b0;
        tick;
        reset_n = 1'b1;
        repeat (3) tick;
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_ovr", overrun, 1'b0);
        e_st = '0; e_pt = '0; e_ps = '0; e_pst = '0;
        e_ovr = 1'b0; prev_ovr_run = 1'b0; prev_fin_eq = 1'b0;

        // Random sequence spacing: overrunning, final-cycle, and complete
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(1, LASTCAP);
                1:       n = LASTCAP + 1;
                default: n = $urandom_range(LASTCAP + 2, 40);
            endcase
            run_seq(n, ($urandom_range(0, 3) == 0), 1'b0);
        end
        run_seq(30, 1'b0, 1'b0);

        repeat (5) tick;
        chk("final_st", st_out, e_st);
        chk("final_pt", pt_out, e_pt);
        chk("final_ps", ps_out, e_ps);
        chk("final_pst", pst_out, e_pst);
        chk("pending_done", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
